instr_fetch_unit: RTL

Multicycle instruction fetch engine that feeds the 32-bit instruction register consumed by `controlUnit`. On a fetch request from the control unit's fetch state, it issues a read at the current PC, waits for instruction memory to respond, and latches the word into IR. It then pulses `ir_valid` and advances the PC by 4, or to a loaded branch target. It sits between instruction memory and the control unit, and owns the architectural PC.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/pc_register.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and instruction/PC constants.
// The FAULT state exists only when FETCH_TIMEOUT_EN is defined.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone
`ifdef FETCH_TIMEOUT_EN
    ,
    StFault
`endif
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned PC_W = 64
) ();
  import cpu_pkg::*;

  logic [PC_W-1:0]    mem_addr;
  logic               mem_rd;
  logic [INSTR_W-1:0] mem_data;
  logic               mem_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data,
    output mem_ready
  );
endinterface

// File: rtl/pc_register.sv
// Architectural PC register: load target (word aligned), increment by 4, or hold.
module pc_register
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic            incr_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  // Wraps modulo 2^PC_W
  assign pc_plus4_o = pc_q + PC_W'(PC_STEP);
  assign pc_o       = pc_q;

  // Next PC: load has priority over increment; low two target bits are forced to zero
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = {target_i[PC_W-1:2], 2'b00};
    end else if (incr_i) begin
      pc_d = pc_plus4_o;
    end
  end

  // PC state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch engine: reads the word at PC, latches it into IR,
// pulses ir_valid and advances PC (sequential or branch target).
// Optional feature macro FETCH_TIMEOUT_EN: bounded wait with a terminal FAULT state
// that injects a NOP and sets the sticky fetch_fault flag.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned     TIMEOUT_CYCLES = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               pc_load,
  input  logic [PC_W-1:0]    pc_target,
  instr_fetch_unit_if.master mem,
  output logic [INSTR_W-1:0] IR,
  output logic               ir_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               busy,
  output logic               fetch_fault
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               pc_ld, pc_inc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            fault_q, fault_d;

  assign cnt_inc = cnt_q + CntW'(1);
`endif

  pc_register #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .load_i     (pc_ld),
    .incr_i     (pc_inc),
    .target_i   (pc_target),
    .pc_o       (pc),
    .pc_plus4_o (pc_plus4)
  );

  // Read request is purely state-decoded so reset removes it asynchronously
  assign mem.mem_rd   = (state_q == StReq) || (state_q == StWait);
  assign mem.mem_addr = pc;
  assign IR           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign busy         = (state_q != StIdle);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault  = fault_q;
`else
  assign fetch_fault  = 1'b0;
`endif

  // Next-state, IR capture and PC control
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    fault_d    = fault_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Load lands at the same edge as the REQ transition, so the fetch sees the new PC
        pc_ld = pc_load;
        if (fetch_req) begin
          state_d = StReq;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StReq, StWait: begin
        if (mem.mem_ready) begin
          ir_d       = mem.mem_data;
          ir_valid_d = 1'b1;
          state_d    = StDone;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_inc;
          if (32'(cnt_inc) >= TIMEOUT_CYCLES) begin
            state_d    = StFault;
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b1;
            fault_d    = 1'b1;
          end else begin
            state_d = StWait;
          end
`else
          state_d = StWait;
`endif
        end
      end
      StDone: begin
        pc_ld   = pc_load;
        pc_inc  = ~pc_load;
        state_d = StIdle;
      end
`ifdef FETCH_TIMEOUT_EN
      StFault: begin
        state_d = StFault;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, IR and valid-pulse registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait-state counter and sticky fault flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
`endif

endmodule
